// File: rtl/cache_ri.sv
// cache_ri: responder side of the cache command channel. Runs block refills, uncached
// single-word IO accesses and bus-free control commands on the memory master port.
// Optional build macro: CACHE_RI_CRITICAL_WORD_FIRST_EN (refill starts at the requested word).
module cache_ri #(
  parameter int BLOCK_WORDS = 16,
  parameter int CNT_WIDTH   = 4
) (
  input  logic        clk,
  input  logic        rest,
  input  logic [3:0]  s_cmd,
  input  logic        s_cmd_valid,
  output logic        s_cmd_ready,
  input  logic [31:0] s_address,
  input  logic [3:0]  s_byteEnable,
  input  logic        s_read,
  input  logic        s_write,
  input  logic [31:0] s_writeData,
  output logic [31:0] m1_address,
  output logic [3:0]  m1_byteEnable,
  output logic        m1_read,
  output logic        m1_write,
  output logic [31:0] m1_writeData,
  input  logic        m1_waitRequest,
  input  logic [31:0] m1_readData,
  input  logic        m1_readDataValid,
  output logic [31:0] ri_wAddr,
  output logic [31:0] ri_wData,
  output logic        ri_wEn,
  output logic        ri_blockDone,
  output logic        ri_critValid,
  output logic [31:0] io_readData,
  output logic        io_readDataValid
);

  typedef enum logic [2:0] {IDLE, RB, IO_REQ, IO_WAIT, DONE} state_t;

  localparam logic [3:0]           CMD_RB     = 4'h1;
  localparam logic [3:0]           CMD_IORW   = 4'h2;
  localparam logic [CNT_WIDTH:0]   FULL       = (CNT_WIDTH + 1)'(BLOCK_WORDS);
  localparam logic [CNT_WIDTH:0]   ONE        = (CNT_WIDTH + 1)'(1);
  localparam logic [31:0]          BLOCK_MASK = 32'(BLOCK_WORDS * 4 - 1);

  state_t               state;
  logic [3:0]           cmd_q;
  logic [31:0]          addr_q;
  logic                 rd_q;
  logic [CNT_WIDTH:0]   icnt;
  logic [CNT_WIDTH:0]   rcnt;

  // Byte address of the cnt-th word of a refill; the word index wraps inside the block.
  function automatic logic [31:0] word_addr(input logic [31:0] a, input logic [CNT_WIDTH:0] cnt);
    logic [31:0]          start;
    logic [CNT_WIDTH-1:0] idx;
`ifdef CACHE_RI_CRITICAL_WORD_FIRST_EN
    start = a >> 2;
`else
    start = '0;
`endif
    idx = CNT_WIDTH'(start + 32'(cnt));
    return (a & ~BLOCK_MASK) | {{(30 - CNT_WIDTH){1'b0}}, idx, 2'b00};
  endfunction

  always_ff @(posedge clk) begin
    if (!rest) begin
      state            <= IDLE;
      cmd_q            <= '0;
      addr_q           <= '0;
      rd_q             <= 1'b0;
      icnt             <= '0;
      rcnt             <= '0;
      s_cmd_ready      <= 1'b0;
      m1_address       <= '0;
      m1_byteEnable    <= '0;
      m1_read          <= 1'b0;
      m1_write         <= 1'b0;
      m1_writeData     <= '0;
      ri_wAddr         <= '0;
      ri_wData         <= '0;
      ri_wEn           <= 1'b0;
      ri_blockDone     <= 1'b0;
      ri_critValid     <= 1'b0;
      io_readData      <= '0;
      io_readDataValid <= 1'b0;
    end else begin
      // NOTE: pulse outputs default low and are raised below for one cycle; every branch
      // reads pre-edge values because all state updates are non-blocking.
      s_cmd_ready      <= 1'b0;
      ri_wEn           <= 1'b0;
      ri_blockDone     <= 1'b0;
      ri_critValid     <= 1'b0;
      io_readDataValid <= 1'b0;

      unique case (state)
        IDLE: begin
          // Ready is still high on the edge where the front end drops valid: do not re-accept.
          if (s_cmd_valid && !s_cmd_ready) begin
            cmd_q  <= s_cmd;
            addr_q <= s_address;
            rd_q   <= s_read;
            if (s_cmd == CMD_RB) begin
              icnt          <= '0;
              rcnt          <= '0;
              m1_read       <= 1'b1;
              m1_write      <= 1'b0;
              m1_byteEnable <= 4'hF;
              m1_address    <= word_addr(s_address, '0);
              state         <= RB;
            end else if (s_cmd == CMD_IORW && (s_read || s_write)) begin
              m1_address    <= s_address & ~32'h3;
              m1_byteEnable <= s_byteEnable;
              m1_read       <= s_read;
              m1_write      <= s_write & ~s_read;
              m1_writeData  <= s_writeData;
              state         <= IO_REQ;
            end else begin
              state <= DONE;
            end
          end
        end

        RB: begin
          if (m1_read && !m1_waitRequest) begin
            icnt <= icnt + ONE;
            if (icnt + ONE == FULL) m1_read <= 1'b0;
            else                    m1_address <= word_addr(addr_q, icnt + ONE);
          end
          if (m1_readDataValid && rcnt != FULL) begin
            ri_wEn   <= 1'b1;
            ri_wData <= m1_readData;
            ri_wAddr <= word_addr(addr_q, rcnt);
            rcnt     <= rcnt + ONE;
`ifdef CACHE_RI_CRITICAL_WORD_FIRST_EN
            ri_critValid <= (rcnt == '0);
`endif
          end else if (rcnt == FULL) begin
            ri_blockDone <= 1'b1;
            state        <= DONE;
          end
        end

        IO_REQ: begin
          if (!m1_waitRequest) begin
            m1_read  <= 1'b0;
            m1_write <= 1'b0;
            state    <= rd_q ? IO_WAIT : DONE;
          end
        end

        IO_WAIT: begin
          if (m1_readDataValid) begin
            io_readData <= m1_readData;
            state       <= DONE;
          end
        end

        DONE: begin
          s_cmd_ready      <= 1'b1;
          io_readDataValid <= (cmd_q == CMD_IORW) && rd_q;
          state            <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_ri.sv
// tb_cache_ri: directed bench for cache_ri with a pipelined memory responder and
// a negedge monitor logging bus accepts, refill writes and completion pulses.
module tb_cache_ri;

`ifdef CACHE_RI_CRITICAL_WORD_FIRST_EN
  localparam int START_OFF = 13;  // word offset of 32'h1234 inside its 64-byte block
  localparam int EXP_CRIT  = 1;
`else
  localparam int START_OFF = 0;
  localparam int EXP_CRIT  = 0;
`endif

  logic        clk = 1'b0;
  logic        rest = 1'b0;
  logic [3:0]  s_cmd = '0;
  logic        s_cmd_valid = 1'b0;
  logic        s_cmd_ready;
  logic [31:0] s_address = '0;
  logic [3:0]  s_byteEnable = '0;
  logic        s_read = 1'b0;
  logic        s_write = 1'b0;
  logic [31:0] s_writeData = '0;
  logic [31:0] m1_address;
  logic [3:0]  m1_byteEnable;
  logic        m1_read;
  logic        m1_write;
  logic [31:0] m1_writeData;
  logic        m1_waitRequest = 1'b0;
  logic [31:0] m1_readData = '0;
  logic        m1_readDataValid = 1'b0;
  logic [31:0] ri_wAddr;
  logic [31:0] ri_wData;
  logic        ri_wEn;
  logic        ri_blockDone;
  logic        ri_critValid;
  logic [31:0] io_readData;
  logic        io_readDataValid;

  cache_ri dut (
    .clk(clk), .rest(rest),
    .s_cmd(s_cmd), .s_cmd_valid(s_cmd_valid), .s_cmd_ready(s_cmd_ready),
    .s_address(s_address), .s_byteEnable(s_byteEnable), .s_read(s_read),
    .s_write(s_write), .s_writeData(s_writeData),
    .m1_address(m1_address), .m1_byteEnable(m1_byteEnable), .m1_read(m1_read),
    .m1_write(m1_write), .m1_writeData(m1_writeData), .m1_waitRequest(m1_waitRequest),
    .m1_readData(m1_readData), .m1_readDataValid(m1_readDataValid),
    .ri_wAddr(ri_wAddr), .ri_wData(ri_wData), .ri_wEn(ri_wEn),
    .ri_blockDone(ri_blockDone), .ri_critValid(ri_critValid),
    .io_readData(io_readData), .io_readDataValid(io_readDataValid)
  );

  always #5 clk = ~clk;

  typedef struct {logic [31:0] addr; logic [3:0] be; logic [31:0] wd; logic wr;} acc_t;
  typedef struct {logic [31:0] data; int due;} beat_t;
  typedef struct {logic [31:0] addr; logic [31:0] data; logic crit; int cyc;} wen_t;

  acc_t  acc_q[$];
  beat_t beat_q[$];
  wen_t  wen_q[$];

  int          cyc = 0;
  int          lat = 1;         // accept-to-data latency of the memory model
  int          wait_mode = 0;   // 0 none, 1 random 50%, 2 stall the next wait_hold request cycles
  int          wait_hold = 0;
  logic [31:0] io_rdata = '0;
  int          req_cycles = 0, wr_cycles = 0, n_bd = 0, n_crit = 0, n_ready = 0;
  int          bd_cyc = 0, rdy_cyc = 0;

  // Memory responder and monitor; inputs change here, half a cycle away from the DUT edge.
  always @(negedge clk) begin
    cyc++;
    m1_readDataValid = 1'b0;
    if (beat_q.size() > 0 && beat_q[0].due <= cyc) begin
      m1_readData      = beat_q[0].data;
      m1_readDataValid = 1'b1;
      void'(beat_q.pop_front());
    end
    case (wait_mode)
      1: m1_waitRequest = 1'($urandom_range(0, 1));
      2: begin
        if ((m1_read || m1_write) && wait_hold > 0) begin
          m1_waitRequest = 1'b1;
          wait_hold--;
        end else begin
          m1_waitRequest = 1'b0;
        end
      end
      default: m1_waitRequest = 1'b0;
    endcase
    if (m1_read || m1_write) req_cycles++;
    if (m1_write) wr_cycles++;
    if ((m1_read || m1_write) && !m1_waitRequest) begin
      acc_q.push_back('{addr: m1_address, be: m1_byteEnable, wd: m1_writeData, wr: m1_write});
      if (m1_read)
        beat_q.push_back('{data: m1_address[31] ? io_rdata
                                 : 32'hA000_0000 + ((m1_address >> 2) & 32'hF),
                           due: cyc + lat});
    end
    if (ri_wEn) wen_q.push_back('{addr: ri_wAddr, data: ri_wData, crit: ri_critValid, cyc: cyc});
    if (ri_critValid) n_crit++;
    if (ri_blockDone) begin n_bd++; bd_cyc = cyc; end
    if (s_cmd_ready) begin n_ready++; rdy_cyc = cyc; end
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_m1_address"}, m1_address, 32'h0);
    check({tag, "_m1_writeData"}, m1_writeData, 32'h0);
    check({tag, "_io_readData"}, io_readData, 32'h0);
    check({tag, "_ri_wAddr"}, ri_wAddr, 32'h0);
    check({tag, "_ri_wData"}, ri_wData, 32'h0);
    check({tag, "_flags"}, 32'({s_cmd_ready, m1_read, m1_write, m1_byteEnable, ri_wEn,
                                ri_blockDone, ri_critValid, io_readDataValid}), 32'h0);
  endtask

  // Called at a negedge: present a command and hold it.
  task automatic start_cmd(input logic [3:0] c, input logic [31:0] a, input logic [3:0] be,
                           input logic rd, input logic wr, input logic [31:0] wd);
    s_cmd = c; s_address = a; s_byteEnable = be;
    s_read = rd; s_write = wr; s_writeData = wd;
    s_cmd_valid = 1'b1;
  endtask

  task automatic wait_ready(input int budget, output int l);
    l = 0;
    do begin
      @(negedge clk);
      l++;
    end while (!s_cmd_ready && l < budget);
    check("ready_seen", 32'(s_cmd_ready), 32'd1);
  endtask

  // Valid stays high through the edge that samples ready, then drops.
  task automatic finish_cmd();
    @(negedge clk);
    s_cmd_valid = 1'b0;
    check("ready_one_cycle", 32'(s_cmd_ready), 32'd0);
  endtask

  task automatic check_refill(input string tag, input int ab, input int wb, input int bb,
                              input int cb);
    int na, nw, off;
    na = acc_q.size() - ab;
    nw = wen_q.size() - wb;
    check_int({tag, "_accepts"}, na, 16);
    for (int i = 0; i < 16 && i < na; i++) begin
      off = (START_OFF + i) % 16;
      check($sformatf("%s_rd_addr%0d", tag, i), acc_q[ab + i].addr, 32'h1200 + 32'(4 * off));
      check($sformatf("%s_rd_kind%0d", tag, i), 32'({acc_q[ab + i].wr, acc_q[ab + i].be}), 32'hF);
    end
    check_int({tag, "_writes"}, nw, 16);
    for (int i = 0; i < 16 && i < nw; i++) begin
      off = (START_OFF + i) % 16;
      check($sformatf("%s_waddr%0d", tag, i), wen_q[wb + i].addr, 32'h1200 + 32'(4 * off));
      check($sformatf("%s_wdata%0d", tag, i), wen_q[wb + i].data, 32'hA000_0000 + 32'(off));
      check($sformatf("%s_crit%0d", tag, i), 32'(wen_q[wb + i].crit),
            32'((i == 0) && (EXP_CRIT == 1)));
    end
    check_int({tag, "_block_done"}, n_bd - bb, 1);
    if (nw == 16) check_int({tag, "_bd_after_last_write"}, bd_cyc, wen_q[wb + 15].cyc + 1);
    check_int({tag, "_ready_after_bd"}, int'(rdy_cyc > bd_cyc), 1);
    check_int({tag, "_crit_pulses"}, n_crit - cb, EXP_CRIT);
  endtask

  initial begin
    int l, ab, wb, bb, cb, rb, sr, sw, snap, budget;

    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rest = 1'b1;
    @(negedge clk);

    // Control command: ready two cycles after valid, no bus traffic, single pulse.
    ab = acc_q.size(); sr = req_cycles; rb = n_ready;
    start_cmd(4'h0, 32'h0000_0040, 4'h0, 1'b0, 1'b0, 32'h0);
    wait_ready(50, l);
    check_int("ctrl_latency", l, 2);
    finish_cmd();
    repeat (4) @(negedge clk);
    check_int("ctrl_ready_pulses", n_ready - rb, 1);
    check_int("ctrl_bus_cycles", req_cycles - sr, 0);

    // Unknown code behaves as control.
    start_cmd(4'h7, 32'h0, 4'h0, 1'b1, 1'b0, 32'h0);
    wait_ready(50, l);
    check_int("other_cmd_latency", l, 2);
    finish_cmd();

    // iorw with neither read nor write: completes without a bus access.
    ab = acc_q.size(); sr = req_cycles;
    start_cmd(4'h2, 32'h8000_0000, 4'hF, 1'b0, 1'b0, 32'h0);
    wait_ready(50, l);
    check_int("iorw_none_latency", l, 2);
    finish_cmd();
    check_int("iorw_none_bus_cycles", req_cycles - sr, 0);

    // Zero-wait refill.
    lat = 1; wait_mode = 0;
    ab = acc_q.size(); wb = wen_q.size(); bb = n_bd; cb = n_crit; sw = wr_cycles;
    start_cmd(4'h1, 32'h0000_1234, 4'hF, 1'b1, 1'b0, 32'h0);
    wait_ready(200, l);
    finish_cmd();
    repeat (3) @(negedge clk);
    check_refill("rb_zero_wait", ab, wb, bb, cb);
    check_int("rb_no_writes_on_bus", wr_cycles - sw, 0);

    // Refill with random stalls and three-cycle data latency.
    lat = 3; wait_mode = 1;
    ab = acc_q.size(); wb = wen_q.size(); bb = n_bd; cb = n_crit;
    start_cmd(4'h1, 32'h0000_1234, 4'hF, 1'b1, 1'b0, 32'h0);
    wait_ready(400, l);
    finish_cmd();
    repeat (6) @(negedge clk);
    check_refill("rb_stall", ab, wb, bb, cb);
    wait_mode = 0; lat = 1;

    // IO write with the request stalled for two cycles.
    ab = acc_q.size(); wb = wen_q.size(); sw = wr_cycles;
    wait_mode = 2; wait_hold = 2;
    start_cmd(4'h2, 32'h8000_0006, 4'hC, 1'b0, 1'b1, 32'hDEAD_BEEF);
    wait_ready(50, l);
    check_int("iow_stall_latency", l, 5);
    finish_cmd();
    wait_mode = 0;
    check_int("iow_accepts", acc_q.size() - ab, 1);
    if (acc_q.size() > ab) begin
      check("iow_addr", acc_q[ab].addr, 32'h8000_0004);
      check("iow_be_wr", 32'({acc_q[ab].wr, acc_q[ab].be}), 32'h1C);
      check("iow_data", acc_q[ab].wd, 32'hDEAD_BEEF);
    end
    check_int("iow_request_cycles", wr_cycles - sw, 3);
    check_int("iow_no_refill_write", wen_q.size() - wb, 0);

    // Zero-wait IO write.
    start_cmd(4'h2, 32'h8000_0008, 4'hF, 1'b0, 1'b1, 32'h0BAD_F00D);
    wait_ready(50, l);
    check_int("iow_zero_wait_latency", l, 3);
    finish_cmd();

    // IO read with four-cycle data latency.
    lat = 4; io_rdata = 32'h1234_5678;
    ab = acc_q.size();
    start_cmd(4'h2, 32'h8000_0013, 4'hF, 1'b1, 1'b0, 32'h0);
    wait_ready(50, l);
    check_int("ior_latency", l, 7);
    check("ior_valid_with_ready", 32'(io_readDataValid), 32'd1);
    check("ior_data", io_readData, 32'h1234_5678);
    finish_cmd();
    check("ior_valid_pulse", 32'(io_readDataValid), 32'd0);
    if (acc_q.size() > ab) check("ior_addr", acc_q[ab].addr, 32'h8000_0010);
    lat = 1;

    // Reset in the middle of a refill, then a clean refill.
    wb = wen_q.size();
    start_cmd(4'h1, 32'h0000_1234, 4'hF, 1'b1, 1'b0, 32'h0);
    budget = 0;
    while (wen_q.size() - wb < 5 && budget < 100) begin
      @(negedge clk);
      budget++;
    end
    check_int("rst_mid_reached_5_words", int'(wen_q.size() - wb >= 5), 1);
    rest = 1'b0;
    s_cmd_valid = 1'b0;
    @(negedge clk);
    check_all_zero("rst_mid");
    @(negedge clk);
    snap = wen_q.size();
    rest = 1'b1;
    repeat (6) @(negedge clk);
    check_int("rst_late_beats_ignored", wen_q.size() - snap, 0);

    ab = acc_q.size(); wb = wen_q.size(); bb = n_bd; cb = n_crit;
    start_cmd(4'h1, 32'h0000_1234, 4'hF, 1'b1, 1'b0, 32'h0);
    wait_ready(200, l);
    finish_cmd();
    repeat (3) @(negedge clk);
    check_refill("rb_after_rst", ab, wb, bb, cb);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/cache_ri.md
Name: cache_ri

Overview:
- Responder side of the cache command channel. Accepts commands issued by the cache read/write front end (m0_cmd/m0_cmd_valid/m0_cmd_ready) and executes them on the external memory master bus.
- Executes three commands:
  - Block refill: a 16-word line is fetched and streamed into the data RAM.
  - Uncached IO read/write: a single word access.
  - Control command: acknowledged with no bus activity.
- Sits between the cache front end and the system interconnect.

Parameters:
- BLOCK_WORDS, 16: words per cache line (power of 2, ≥2); the refill length.
- CNT_WIDTH, 4: log2(BLOCK_WORDS); width of the issue and receive counters.

Ports:
- clk  in  1  clock.
- rest  in  1  synchronous active-low reset.
- s_cmd  in  4  command: 4'h1 = rb (block refill), 4'h2 = iorw (uncached access), 4'h0 = control; any other code is treated as control.
- s_cmd_valid  in  1  command valid; held high until s_cmd_ready.
- s_cmd_ready  out  1  one-cycle completion pulse.
- s_address  in  32  byte address of the pending access; stable while s_cmd_valid.
- s_byteEnable  in  4  byte enables of the pending access.
- s_read  in  1  pending access is a read.
- s_write  in  1  pending access is a write.
- s_writeData  in  32  write data of the pending access.
- m1_address  out  32  memory bus address (word aligned).
- m1_byteEnable  out  4  memory bus byte enables.
- m1_read  out  1  memory bus read request.
- m1_write  out  1  memory bus write request.
- m1_writeData  out  32  memory bus write data.
- m1_waitRequest  in  1  bus stall; a request is accepted when it is asserted and m1_waitRequest=0.
- m1_readData  in  32  bus read data.
- m1_readDataValid  in  1  bus read data valid; pipelined, returned in issue order.
- ri_wAddr  out  32  byte address of the refill word being written to the data RAM.
- ri_wData  out  32  refill word.
- ri_wEn  out  1  refill word write strobe.
- ri_blockDone  out  1  one-cycle pulse after the last refill word; the tag/readable bits are updated on it.
- ri_critValid  out  1  pulse when the requested word of a refill arrives (see Optional Feature).
- io_readData  out  32  uncached read result.
- io_readDataValid  out  1  one-cycle pulse qualifying io_readData.

Behaviour:
- Reset (rest=0 at a clk edge):
  - State goes to IDLE; both counters clear.
  - All outputs go to 0: s_cmd_ready, m1_read, m1_write, m1_address, m1_byteEnable, m1_writeData, ri_wEn, ri_blockDone, ri_critValid, io_readData, io_readDataValid, ri_wAddr, ri_wData.
  - Reset mid-operation abandons the transfer. Late m1_readDataValid beats arriving in IDLE are ignored.
- States: IDLE, RB, IO_REQ, IO_WAIT, DONE.
- IDLE:
  - When s_cmd_valid=1, latch s_cmd, s_address, s_byteEnable, s_read, s_write and s_writeData.
  - Next state: rb → RB; iorw → IO_REQ; otherwise → DONE.
  - iorw with both s_read=0 and s_write=0 → DONE with no bus access.
- RB:
  - Block base = latched address with bits [log2(BLOCK_WORDS*4)-1:0] cleared.
  - Issue side:
    - m1_read=1 and m1_byteEnable=4'hF while the issue count is below BLOCK_WORDS.
    - m1_address = base + 4*issue word index.
    - The issue counter advances on each accepted request.
    - m1_read drops in the cycle after the last accept.
  - Receive side:
    - Each m1_readDataValid beat registers ri_wEn=1, ri_wData=m1_readData and ri_wAddr = base + 4*receive word index.
    - ri_wEn is asserted one cycle after the beat.
    - The receive counter increments; issue and receive run concurrently.
  - After the final beat's write cycle: ri_blockDone=1 for one cycle, then → DONE.
- IO_REQ:
  - Drive the latched word-aligned address and the latched byteEnable; m1_read or m1_write follows the latch (read takes priority if both are set). m1_writeData = latched data.
  - Hold until m1_waitRequest=0.
  - Write → DONE. Read → IO_WAIT.
- IO_WAIT:
  - On m1_readDataValid, register io_readData and pulse io_readDataValid; go to DONE.
  - io_readDataValid coincides with the s_cmd_ready pulse.
- DONE:
  - s_cmd_ready=1 for exactly one cycle, then → IDLE.
  - A command is never re-accepted in the same cycle that ready is pulsed.
  - The front end drops s_cmd_valid on that same edge.
- Latency:
  - Control command: ready two cycles after valid is first sampled.
  - Zero-wait-state IO write: ready three cycles after valid.
- Counters are CNT_WIDTH+1 bits so that BLOCK_WORDS itself is representable; word indices wrap modulo BLOCK_WORDS.

Optional Feature:
- Macro: CACHE_RI_CRITICAL_WORD_FIRST_EN.
- Defined:
  - Refill issue starts at the word offset of the latched address and wraps modulo BLOCK_WORDS; ri_wAddr follows the same order.
  - ri_critValid pulses together with the ri_wEn of the first word.
- Not defined:
  - Refill order is always offset 0 through BLOCK_WORDS-1.
  - ri_critValid is tied to 0.

Test Plan:
- Control command (s_cmd=0, valid held): s_cmd_ready pulses exactly once, 2 cycles after valid is first sampled; m1_read and m1_write stay 0 throughout.
- Refill with zero wait states: s_cmd=1, s_address=32'h0000_1234, memory returns word k = 32'hA000_0000+k.
  - 16 reads at 32'h1200..32'h123C.
  - 16 ri_wEn pulses with matching ri_wAddr and ri_wData.
  - ri_blockDone once after the last write, then s_cmd_ready.
- Refill under stalls: m1_waitRequest random 50% and readDataValid delayed 3 cycles → still exactly 16 accepts, in-order writes, one ri_blockDone.
- IO write: s_address=32'h8000_0006, byteEnable 4'hC, data 32'hDEAD_BEEF, waitRequest held for 2 cycles.
  - m1_address = 32'h8000_0004; request held 3 cycles.
  - s_cmd_ready the cycle after acceptance; no ri_wEn.
- IO read returning 32'h1234_5678 after 4 cycles → io_readData = 32'h1234_5678 with io_readDataValid and s_cmd_ready in the same cycle.
- Reset asserted mid-refill after 5 words → all outputs 0 next cycle; a following rb command completes normally with 16 fresh writes.
  - With CACHE_RI_CRITICAL_WORD_FIRST_EN and s_address=32'h1234, the first issued address is 32'h1234 and the last is 32'h1230.
